// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the MIPS memory arbiter: FSM state type,
// AXI OKAY response code and the data width.
package mips_mem_arb_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        CPU_RD,
        HOST_RD,
        HOST_RRESP,
        HOST_BRESP
    } arb_state_e;

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin arbiter: req[0]/grant[0] is the CPU, req[1]/grant[1] the host.
// After reset the host wins a tie; the pointer moves only when something is granted.
module mips_rr_arb2 (
    input  logic       mips_cpu_clk,
    input  logic       mips_cpu_reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic host_last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = host_last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            host_last_q <= 1'b0;
        end else if (|grant) begin
            host_last_q <= grant[1];
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one shared single-port memory between the MIPS CPU and an AXI-lite host.
// Optional MIPS_MEM_ARB_ADDR_CHECK_EN: CPU accesses beyond ADDR_WIDTH are granted but suppressed.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  mips_cpu_clk,
    input  logic                  mips_cpu_reset,

    input  logic [ADDR_WIDTH-1:0] mips_cpu_axi_if_awaddr,
    input  logic                  mips_cpu_axi_if_awvalid,
    output logic                  mips_cpu_axi_if_awready,
    input  logic [DATA_WIDTH-1:0] mips_cpu_axi_if_wdata,
    input  logic [3:0]            mips_cpu_axi_if_wstrb,
    input  logic                  mips_cpu_axi_if_wvalid,
    output logic                  mips_cpu_axi_if_wready,
    output logic [1:0]            mips_cpu_axi_if_bresp,
    output logic                  mips_cpu_axi_if_bvalid,
    input  logic                  mips_cpu_axi_if_bready,
    input  logic [ADDR_WIDTH-1:0] mips_cpu_axi_if_araddr,
    input  logic                  mips_cpu_axi_if_arvalid,
    output logic                  mips_cpu_axi_if_arready,
    output logic [DATA_WIDTH-1:0] mips_cpu_axi_if_rdata,
    output logic [1:0]            mips_cpu_axi_if_rresp,
    output logic                  mips_cpu_axi_if_rvalid,
    input  logic                  mips_cpu_axi_if_rready,

    input  logic                  cpu_mem_req,
    input  logic                  cpu_mem_wen,
    input  logic [31:0]           cpu_mem_addr,
    input  logic [3:0]            cpu_mem_wstrb,
    input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
    output logic                  cpu_mem_grant,
    output logic [DATA_WIDTH-1:0] cpu_mem_rdata,
    output logic                  cpu_mem_rvalid,

    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e state_q;
    logic       bvalid_q;
    logic       rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic       cpu_rd_err_q;

    logic       host_wr_req;
    logic       host_rd_req;
    logic       arb_en;
    logic [1:0] rr_req;
    logic [1:0] rr_grant;
    logic       cpu_gnt;
    logic       host_wr_gnt;
    logic       host_rd_gnt;
    logic       cpu_addr_err;
    logic       unused_addr_bits;

    // A host write needs both AW and W so the two ready signals can fire together.
    assign host_wr_req = mips_cpu_axi_if_awvalid & mips_cpu_axi_if_wvalid;
    assign host_rd_req = mips_cpu_axi_if_arvalid;
    assign arb_en      = (state_q == IDLE) & ~mips_cpu_reset;
    assign rr_req      = {host_wr_req | host_rd_req, cpu_mem_req} & {2{arb_en}};

    mips_rr_arb2 u_rr_arb2 (
        .mips_cpu_clk   (mips_cpu_clk),
        .mips_cpu_reset (mips_cpu_reset),
        .req            (rr_req),
        .grant          (rr_grant)
    );

    assign cpu_gnt     = rr_grant[0];
    assign host_wr_gnt = rr_grant[1] & host_wr_req;
    assign host_rd_gnt = rr_grant[1] & ~host_wr_req;

`ifdef MIPS_MEM_ARB_ADDR_CHECK_EN
    assign cpu_addr_err     = |cpu_mem_addr[31:ADDR_WIDTH];
    assign unused_addr_bits = ^{cpu_mem_addr[1:0], mips_cpu_axi_if_awaddr[1:0],
                                mips_cpu_axi_if_araddr[1:0]};
`else
    assign cpu_addr_err     = 1'b0;
    assign unused_addr_bits = ^{cpu_mem_addr[31:ADDR_WIDTH], cpu_mem_addr[1:0],
                                mips_cpu_axi_if_awaddr[1:0], mips_cpu_axi_if_araddr[1:0]};
`endif

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = ~cpu_addr_err;
            mem_we    = (cpu_mem_wen & ~cpu_addr_err) ? cpu_mem_wstrb : 4'b0000;
            mem_addr  = cpu_mem_addr[ADDR_WIDTH-1:2];
            mem_wdata = cpu_mem_wdata;
        end else if (host_wr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = mips_cpu_axi_if_wstrb;
            mem_addr  = mips_cpu_axi_if_awaddr[ADDR_WIDTH-1:2];
            mem_wdata = mips_cpu_axi_if_wdata;
        end else if (host_rd_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = mips_cpu_axi_if_araddr[ADDR_WIDTH-1:2];
        end
    end

    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            state_q      <= IDLE;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            cpu_rd_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_gnt) begin
                        if (!cpu_mem_wen) begin
                            state_q      <= CPU_RD;
                            cpu_rd_err_q <= cpu_addr_err;
                        end
                    end else if (host_wr_gnt) begin
                        state_q  <= HOST_BRESP;
                        bvalid_q <= 1'b1;
                    end else if (host_rd_gnt) begin
                        state_q <= HOST_RD;
                    end
                end
                CPU_RD: state_q <= IDLE;
                HOST_RD: begin
                    rdata_q  <= mem_rdata;
                    rvalid_q <= 1'b1;
                    state_q  <= HOST_RRESP;
                end
                HOST_RRESP: begin
                    if (mips_cpu_axi_if_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                HOST_BRESP: begin
                    if (mips_cpu_axi_if_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_mem_grant           = cpu_gnt;
    assign cpu_mem_rvalid          = (state_q == CPU_RD);
    assign cpu_mem_rdata           = (state_q == CPU_RD && !cpu_rd_err_q) ? mem_rdata : '0;
    assign mips_cpu_axi_if_awready = host_wr_gnt;
    assign mips_cpu_axi_if_wready  = host_wr_gnt;
    assign mips_cpu_axi_if_arready = host_rd_gnt;
    assign mips_cpu_axi_if_bvalid  = bvalid_q;
    assign mips_cpu_axi_if_bresp   = RESP_OKAY;
    assign mips_cpu_axi_if_rvalid  = rvalid_q;
    assign mips_cpu_axi_if_rdata   = rdata_q;
    assign mips_cpu_axi_if_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed testbench for mips_mem_arbiter with a behavioural 1-cycle-latency memory.
// Define MIPS_MEM_ARB_ADDR_CHECK_EN to exercise the out-of-range CPU access path.
module tb_mips_mem_arbiter;

    logic        mips_cpu_clk = 1'b0;
    logic        mips_cpu_reset;
    logic [13:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        cpu_mem_req, cpu_mem_wen, cpu_mem_grant, cpu_mem_rvalid;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_model [4096];

    always #5 mips_cpu_clk = ~mips_cpu_clk;

    mips_mem_arbiter #(.ADDR_WIDTH(14)) dut (
        .mips_cpu_clk            (mips_cpu_clk),
        .mips_cpu_reset          (mips_cpu_reset),
        .mips_cpu_axi_if_awaddr  (awaddr),
        .mips_cpu_axi_if_awvalid (awvalid),
        .mips_cpu_axi_if_awready (awready),
        .mips_cpu_axi_if_wdata   (wdata),
        .mips_cpu_axi_if_wstrb   (wstrb),
        .mips_cpu_axi_if_wvalid  (wvalid),
        .mips_cpu_axi_if_wready  (wready),
        .mips_cpu_axi_if_bresp   (bresp),
        .mips_cpu_axi_if_bvalid  (bvalid),
        .mips_cpu_axi_if_bready  (bready),
        .mips_cpu_axi_if_araddr  (araddr),
        .mips_cpu_axi_if_arvalid (arvalid),
        .mips_cpu_axi_if_arready (arready),
        .mips_cpu_axi_if_rdata   (rdata),
        .mips_cpu_axi_if_rresp   (rresp),
        .mips_cpu_axi_if_rvalid  (rvalid),
        .mips_cpu_axi_if_rready  (rready),
        .cpu_mem_req             (cpu_mem_req),
        .cpu_mem_wen             (cpu_mem_wen),
        .cpu_mem_addr            (cpu_mem_addr),
        .cpu_mem_wstrb           (cpu_mem_wstrb),
        .cpu_mem_wdata           (cpu_mem_wdata),
        .cpu_mem_grant           (cpu_mem_grant),
        .cpu_mem_rdata           (cpu_mem_rdata),
        .cpu_mem_rvalid          (cpu_mem_rvalid),
        .mem_en                  (mem_en),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata)
    );

    // Read-first single-port memory, data valid one cycle after mem_en.
    always @(posedge mips_cpu_clk) begin
        if (mem_en) begin
            mem_rdata <= mem_model[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge mips_cpu_clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [31:0] exp_word);
        cpu_mem_req = 1'b1; cpu_mem_wen = 1'b1;
        cpu_mem_addr = a; cpu_mem_wdata = d; cpu_mem_wstrb = s;
        #1;
        check("cpu_wr_grant", 32'(cpu_mem_grant), 32'h1);
        check("cpu_wr_we", 32'(mem_we), 32'(s));
        check("cpu_wr_addr", 32'(mem_addr), exp_word);
        tick();
        cpu_mem_req = 1'b0; cpu_mem_wen = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp_word,
                            input logic [31:0] exp_data);
        cpu_mem_req = 1'b1; cpu_mem_wen = 1'b0; cpu_mem_addr = a;
        #1;
        check("cpu_rd_grant", 32'(cpu_mem_grant), 32'h1);
        check("cpu_rd_en", 32'(mem_en), 32'h1);
        check("cpu_rd_we", 32'(mem_we), 32'h0);
        check("cpu_rd_addr", 32'(mem_addr), exp_word);
        tick();
        cpu_mem_req = 1'b0;
        check("cpu_rvalid", 32'(cpu_mem_rvalid), 32'h1);
        check("cpu_rdata", cpu_mem_rdata, exp_data);
        tick();
        check("cpu_rvalid_pulse", 32'(cpu_mem_rvalid), 32'h0);
    endtask

    logic [8:0] exp_ar;
    logic [8:0] exp_gnt;

    initial begin
        mips_cpu_reset = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        cpu_mem_req = 0; cpu_mem_wen = 0; cpu_mem_addr = '0; cpu_mem_wstrb = '0;
        cpu_mem_wdata = '0;
        tick();
        tick();
        // Reset state
        check("rst_awready", 32'(awready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_grant", 32'(cpu_mem_grant), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_rdata", rdata, 0);
        check("rst_cpu_rdata", cpu_mem_rdata, 0);
        mips_cpu_reset = 1'b0;
        tick();

        // Host write then read at 0x0010
        awaddr = 14'h0010; awvalid = 1; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        #1;
        check("hw_awready", 32'(awready), 1);
        check("hw_wready", 32'(wready), 1);
        check("hw_mem_en", 32'(mem_en), 1);
        check("hw_mem_we", 32'(mem_we), 32'hF);
        check("hw_mem_addr", 32'(mem_addr), 32'h004);
        tick();
        awvalid = 0; wvalid = 0;
        check("hw_bvalid", 32'(bvalid), 1);
        check("hw_bresp", 32'(bresp), 0);
        tick();
        check("hw_bvalid_hold", 32'(bvalid), 1);
        bready = 1;
        tick();
        bready = 0;
        check("hw_bvalid_clr", 32'(bvalid), 0);
        araddr = 14'h0010; arvalid = 1;
        #1;
        check("hr_arready", 32'(arready), 1);
        check("hr_mem_addr", 32'(mem_addr), 32'h004);
        check("hr_mem_we", 32'(mem_we), 0);
        tick();
        arvalid = 0;
        check("hr_rvalid_early", 32'(rvalid), 0);
        tick();
        check("hr_rvalid", 32'(rvalid), 1);
        check("hr_rdata", rdata, 32'hDEADBEEF);
        check("hr_rresp", 32'(rresp), 0);
        rready = 1;
        tick();
        rready = 0;
        check("hr_rvalid_clr", 32'(rvalid), 0);

        // CPU writes, including a partial strobe
        cpu_write(32'h20, 32'hCAFE0008, 4'hF, 32'h8);
        cpu_write(32'h24, 32'hAABBCCDD, 4'hF, 32'h9);
        cpu_write(32'h24, 32'h11223344, 4'h3, 32'h9);
        cpu_write(32'h00, 32'h0BAD0000, 4'hF, 32'h0);

        // CPU reads: grant in N, rvalid in N+1
        cpu_read(32'h20, 32'h8, 32'hCAFE0008);
        cpu_read(32'h24, 32'h9, 32'hAABB3344);

        // CPU and host read every cycle: host, CPU, host, CPU
        exp_ar  = 9'b000100001;
        exp_gnt = 9'b100001000;
        cpu_mem_req = 1; cpu_mem_wen = 0; cpu_mem_addr = 32'h20;
        araddr = 14'h0010; arvalid = 1; rready = 1;
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("rr_ar%0d", i), 32'(arready), 32'(exp_ar[i]));
            check($sformatf("rr_gnt%0d", i), 32'(cpu_mem_grant), 32'(exp_gnt[i]));
            tick();
        end
        cpu_mem_req = 0; arvalid = 0; rready = 0;
        tick();

        // AW without W must not be accepted
        awaddr = 14'h0030; awvalid = 1; wvalid = 0; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("aw_only_awready%0d", i), 32'(awready), 0);
            check($sformatf("aw_only_wready%0d", i), 32'(wready), 0);
            tick();
        end
        wvalid = 1;
        #1;
        check("aw_w_awready", 32'(awready), 1);
        check("aw_w_wready", 32'(wready), 1);
        tick();
        awvalid = 0; wvalid = 0; bready = 1;
        check("aw_w_bvalid", 32'(bvalid), 1);
        tick();
        bready = 0;

        // Back-pressured host read with a waiting CPU
        araddr = 14'h0030; arvalid = 1;
        #1;
        check("bp_arready", 32'(arready), 1);
        tick();
        arvalid = 0; cpu_mem_req = 1; cpu_mem_wen = 0; cpu_mem_addr = 32'h20;
        #1;
        check("bp_gnt_hostrd", 32'(cpu_mem_grant), 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_rvalid%0d", i), 32'(rvalid), 1);
            check($sformatf("bp_rdata%0d", i), rdata, 32'h5A5A5A5A);
            check($sformatf("bp_gnt%0d", i), 32'(cpu_mem_grant), 0);
            tick();
        end
        rready = 1;
        #1;
        check("bp_gnt_hs", 32'(cpu_mem_grant), 0);
        tick();
        rready = 0;
        #1;
        check("bp_gnt_after", 32'(cpu_mem_grant), 1);
        check("bp_gnt_addr", 32'(mem_addr), 32'h8);
        tick();
        cpu_mem_req = 0;
        check("bp_cpu_rvalid", 32'(cpu_mem_rvalid), 1);
        check("bp_cpu_rdata", cpu_mem_rdata, 32'hCAFE0008);
        tick();

        // Reset while in HOST_BRESP aborts the response
        awaddr = 14'h0040; awvalid = 1; wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        check("rb_bvalid", 32'(bvalid), 1);
        mips_cpu_reset = 1;
        tick();
        check("rb_bvalid_abort", 32'(bvalid), 0);
        check("rb_rdata_clr", rdata, 0);
        mips_cpu_reset = 0;
        tick();

        // After reset a tie goes to the host
        cpu_mem_req = 1; cpu_mem_addr = 32'h20; araddr = 14'h0010; arvalid = 1;
        #1;
        check("rst_tie_ar", 32'(arready), 1);
        check("rst_tie_gnt", 32'(cpu_mem_grant), 0);
        tick();
        arvalid = 0; rready = 1;
        tick();
        check("rst_tie_rdata", rdata, 32'hDEADBEEF);
        tick();
        rready = 0;
        #1;
        check("rst_tie_cpu", 32'(cpu_mem_grant), 1);
        tick();
        cpu_mem_req = 0;
        tick();

`ifdef MIPS_MEM_ARB_ADDR_CHECK_EN
        cpu_mem_req = 1; cpu_mem_wen = 0; cpu_mem_addr = 32'h0001_0000;
        #1;
        check("oor_grant", 32'(cpu_mem_grant), 1);
        check("oor_mem_en", 32'(mem_en), 0);
        tick();
        cpu_mem_req = 0;
        check("oor_rvalid", 32'(cpu_mem_rvalid), 1);
        check("oor_rdata", cpu_mem_rdata, 0);
        tick();
`else
        // Upper address bits ignored: 0x0001_0000 aliases word 0
        cpu_read(32'h0001_0000, 32'h0, 32'h0BAD0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, byte-address width of the shared memory; word index = addr[ADDR_WIDTH-1:2].
REQ-002 SHALL have mips_cpu_clk, input, 1: the only clock.
REQ-003 SHALL have mips_cpu_reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have host AW channel: mips_cpu_axi_if_awaddr in ADDR_WIDTH, mips_cpu_axi_if_awvalid in 1, mips_cpu_axi_if_awready out 1.
REQ-005 SHALL have host W channel: mips_cpu_axi_if_wdata in 32, mips_cpu_axi_if_wstrb in 4, mips_cpu_axi_if_wvalid in 1, mips_cpu_axi_if_wready out 1.
REQ-006 SHALL have host B channel: mips_cpu_axi_if_bresp out 2, mips_cpu_axi_if_bvalid out 1, mips_cpu_axi_if_bready in 1.
REQ-007 SHALL have host AR channel: mips_cpu_axi_if_araddr in ADDR_WIDTH, mips_cpu_axi_if_arvalid in 1, mips_cpu_axi_if_arready out 1.
REQ-008 SHALL have host R channel: mips_cpu_axi_if_rdata out 32, mips_cpu_axi_if_rresp out 2, mips_cpu_axi_if_rvalid out 1, mips_cpu_axi_if_rready in 1.
REQ-009 SHALL have CPU request: cpu_mem_req in 1, cpu_mem_wen in 1, cpu_mem_addr in 32, cpu_mem_wstrb in 4, cpu_mem_wdata in 32, cpu_mem_grant out 1 (request accepted this cycle).
REQ-010 SHALL have CPU response: cpu_mem_rdata out 32, cpu_mem_rvalid out 1 (one-cycle pulse).
REQ-011 SHALL have memory port: mem_en out 1, mem_we out 4, mem_addr out ADDR_WIDTH-2, mem_wdata out 32, mem_rdata in 32 (valid one cycle after mem_en).

Function
REQ-012 SHALL use FSM states IDLE, CPU_RD, HOST_RD, HOST_RRESP, HOST_BRESP; exactly one memory access is issued per IDLE cycle, none in other states.
REQ-013 SHALL treat requesters in IDLE as CPU (cpu_mem_req), host write (awvalid AND wvalid), host read (arvalid); a host write beats a host read.
REQ-014 SHALL arbitrate CPU vs host round-robin: when both request, the side not granted last wins; the pointer updates only on a grant.
REQ-015 CPU write grant: cpu_mem_grant=1, mem_en=1, mem_we=cpu_mem_wstrb in the same cycle; stay in IDLE.
REQ-016 CPU read grant: cpu_mem_grant=1, mem_en=1, mem_we=0; go to CPU_RD, where cpu_mem_rdata=mem_rdata and cpu_mem_rvalid=1 for exactly one cycle; then IDLE. Read latency is 1 cycle after grant.
REQ-017 Host write grant: awready=wready=1 in the same cycle, mem write with wstrb; go to HOST_BRESP; bvalid=1 held until bready, then IDLE.
REQ-018 Host read grant: arready=1, mem_en=1; HOST_RD registers mem_rdata into rdata; HOST_RRESP holds rvalid=1 until rready, then IDLE.
REQ-019 rdata SHALL stay stable while rvalid=1; bresp and rresp SHALL always be 2'b00.
REQ-020 awready and wready SHALL never assert when only one of awvalid or wvalid is high.
REQ-021 A request arriving in a non-IDLE state SHALL wait, and the CPU request SHALL be held by the CPU until cpu_mem_grant.

Reset
REQ-022 On mips_cpu_reset: state=IDLE, the round-robin pointer favours host, and all ready, valid, grant, mem_en and mem_we outputs are 0; rdata and cpu_mem_rdata are 0.
REQ-023 Reset during any state SHALL abort the transaction at the next edge without issuing a response.

Configuration
REQ-024 With MIPS_MEM_ARB_ADDR_CHECK_EN defined, a CPU access with cpu_mem_addr[31:ADDR_WIDTH]!=0 SHALL still be granted, with mem_en=0. Writes are dropped. Reads pass through CPU_RD with cpu_mem_rdata=0.
REQ-025 Without MIPS_MEM_ARB_ADDR_CHECK_EN, the upper address bits are ignored and aliasing occurs.

Structure
REQ-026 The package mips_mem_arb_pkg SHALL hold the FSM state type, the RESP_OKAY constant and the data width (32).
REQ-027 Two-way round-robin selection SHALL live in the sub-module mips_rr_arb2 (req[1:0], grant[1:0], pointer update on grant).

Verification
REQ-028 Host write at 0x0010 with data 0xDEADBEEF and wstrb F, then host read at 0x0010 -> rdata 0xDEADBEEF, mem_addr 0x004, bresp and rresp 0.
REQ-029 CPU read at 0x20 on an idle bus -> grant in cycle N, rvalid in N+1 with the memory word.
REQ-030 CPU and host read requested every cycle -> grants alternate host, CPU, host, ...
REQ-031 awvalid=1 with wvalid=0 for 5 cycles -> no awready; wvalid rises -> awready=wready=1 in the same cycle.
REQ-032 rready held low 10 cycles -> rvalid and rdata stable, CPU req waits, CPU grant occurs the cycle after the rready handshake returns to IDLE.
REQ-033 Reset asserted in HOST_BRESP -> bvalid=0 next cycle; with MIPS_MEM_ARB_ADDR_CHECK_EN, a CPU read at 0x0001_0000 -> mem_en=0, cpu_mem_rdata=0.
